// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
//
// Time-multiplexed scan driver for an 8-digit seven-segment display. Holds a
// 32-bit hex value (eight nibbles) plus a per-digit blank mask and walks the
// digit positions p = 0..7, presenting each nibble and its anode-select code to
// the external hex-to-segment decoder. New values arrive over a valid/ready
// handshake and are only applied at a frame boundary so a frame never tears.
//
// Ports
//   clk         system clock
//   rst_n       synchronous active-low reset
//   load_valid  producer offers load_data / load_blank
//   load_ready  driver can accept a new value (pending slot empty)
//   load_data   hex value, nibble p = bits [4p+3:4p], p=0 rightmost digit
//   load_blank  bit p = 1 forces digit p dark
//   nibble      digit code to the decoder
//   sel         anode-select code, position p driven as 7-p
//   blank       1 = current digit must be dark
//   frame_done  one-cycle pulse while position 7 finishes its dwell
// -----------------------------------------------------------------------------
module seg_scan_driver #(
    parameter int TICK_DIV    = 100000,
    parameter bit SUPPRESS_LZ = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [31:0] load_data,
    input  logic [7:0]  load_blank,
    output logic [3:0]  nibble,
    output logic [2:0]  sel,
    output logic        blank,
    output logic        frame_done
);

    localparam int            CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] TC = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    pos_q, pos_d;
    logic [31:0]   act_val_q, act_val_d;
    logic [7:0]    act_mask_q, act_mask_d;
    logic [31:0]   pend_val_q, pend_val_d;
    logic [7:0]    pend_mask_q, pend_mask_d;
    logic          pend_full_q, pend_full_d;
    logic [3:0]    nibble_q, nibble_d;
    logic [2:0]    sel_q, sel_d;
    logic          blank_q, blank_d;

    logic          wrap;
    logic          xfer;
    logic          frame_end;
    logic [7:0]    zero_tail;
    logic          tail_zero;

    assign wrap       = (cnt_q == TC);
    assign frame_end  = wrap && (pos_q == 3'd7);
    assign xfer       = load_valid && !pend_full_q;

    assign load_ready = !pend_full_q;
    assign frame_done = frame_end;
    assign nibble     = nibble_q;
    assign sel        = sel_q;
    assign blank      = blank_q;

    // zero_tail[p] = 1 when nibbles p..7 of the active value are all zero,
    // i.e. digit p is a leading zero.
    always_comb begin
        zero_tail = '0;
        tail_zero = 1'b1;
        for (int p = 7; p >= 0; p--) begin
            tail_zero    = tail_zero && (act_val_q[4*p +: 4] == 4'd0);
            zero_tail[p] = tail_zero;
        end
    end

    always_comb begin
        cnt_d       = wrap ? '0 : cnt_q + 1'b1;
        pos_d       = wrap ? pos_q + 3'd1 : pos_q;
        act_val_d   = act_val_q;
        act_mask_d  = act_mask_q;
        pend_val_d  = pend_val_q;
        pend_mask_d = pend_mask_q;
        pend_full_d = pend_full_q;

        if (frame_end) begin
            if (pend_full_q) begin
                act_val_d   = pend_val_q;
                act_mask_d  = pend_mask_q;
                pend_full_d = 1'b0;
            end else if (xfer) begin
                // Pending is empty and the boundary is now: skip the pending
                // slot so load_ready never drops.
                act_val_d  = load_data;
                act_mask_d = load_blank;
            end
        end else if (xfer) begin
            pend_val_d  = load_data;
            pend_mask_d = load_blank;
            pend_full_d = 1'b1;
        end
    end

    // Outputs follow pos_q with one cycle of latency; active value only
    // changes together with the p=7 -> 0 step, so each frame stays coherent.
    always_comb begin
        nibble_d = act_val_q[{pos_q, 2'b00} +: 4];
        sel_d    = 3'd7 - pos_q;
        blank_d  = act_mask_q[pos_q] ||
                   (SUPPRESS_LZ && (pos_q != 3'd0) && zero_tail[pos_q]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            pos_q       <= 3'd0;
            act_val_q   <= '0;
            act_mask_q  <= '0;
            pend_val_q  <= '0;
            pend_mask_q <= '0;
            pend_full_q <= 1'b0;
            nibble_q    <= 4'd0;
            sel_q       <= 3'd7;
            blank_q     <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            pos_q       <= pos_d;
            act_val_q   <= act_val_d;
            act_mask_q  <= act_mask_d;
            pend_val_q  <= pend_val_d;
            pend_mask_q <= pend_mask_d;
            pend_full_q <= pend_full_d;
            nibble_q    <= nibble_d;
            sel_q       <= sel_d;
            blank_q     <= blank_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_driver
//
// Directed bench for seg_scan_driver with TICK_DIV=4, SUPPRESS_LZ=1.
// Cycle k = state after k rising edges since reset release; a frame is 32
// cycles and the display outputs lag the position by one cycle, so position p
// of a frame starting at cycle F is visible on cycles F+1+4p .. F+4+4p.
// -----------------------------------------------------------------------------
module tb_seg_scan_driver;

    logic        clk;
    logic        rst_n;
    logic        load_valid;
    logic        load_ready;
    logic [31:0] load_data;
    logic [7:0]  load_blank;
    logic [3:0]  nibble;
    logic [2:0]  sel;
    logic        blank;
    logic        frame_done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    seg_scan_driver #(
        .TICK_DIV    (4),
        .SUPPRESS_LZ (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_blank (load_blank),
        .nibble     (nibble),
        .sel        (sel),
        .blank      (blank),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic disp_check(input string tag, input int es, input int en, input int eb);
        check({tag, ".sel"},    32'(sel),    32'(es));
        check({tag, ".nibble"}, 32'(nibble), 32'(en));
        check({tag, ".blank"},  32'(blank),  32'(eb));
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    logic [3:0] exp_nib[8];
    logic       exp_blk[8];

    initial begin
        rst_n      = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        load_blank = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;

        // Reset state
        check("rst.load_ready", 32'(load_ready), 32'd1);
        check("rst.frame_done", 32'(frame_done), 32'd0);
        disp_check("rst", 7, 0, 0);

        // Idle scan: zero value, leading-zero blanking on p=1..7
        for (int k = 1; k <= 40; k++) begin
            int ep;
            tick();
            ep = ((cyc - 1) / 4) % 8;
            disp_check("idle", 7 - ep, 0, (ep != 0) ? 1 : 0);
            check("idle.frame_done", 32'(frame_done), (cyc % 32 == 31) ? 32'd1 : 32'd0);
        end

        // Load 0x1234ABCD mid-frame (frame 1 = cycles 32..63)
        run_to(44);
        check("ld1.ready_before", 32'(load_ready), 32'd1);
        load_valid = 1'b1;
        load_data  = 32'h1234ABCD;
        load_blank = 8'h00;
        tick();
        load_valid = 1'b0;
        check("ld1.ready_after", 32'(load_ready), 32'd0);
        run_to(50);
        disp_check("ld1.unchanged", 3, 0, 1);
        run_to(63);
        check("ld1.frame_done", 32'(frame_done), 32'd1);
        check("ld1.ready_at_fd", 32'(load_ready), 32'd0);
        tick();
        check("ld1.ready_commit", 32'(load_ready), 32'd1);
        disp_check("ld1.lag", 0, 0, 1);
        exp_nib = '{4'hD, 4'hC, 4'hB, 4'hA, 4'h4, 4'h3, 4'h2, 4'h1};
        for (int p = 0; p < 8; p++) begin
            run_to(66 + 4 * p);
            disp_check("ld1.frame", 7 - p, 32'(exp_nib[p]), 0);
        end

        // Load A while idle, then offer B while pending is full (frame 3 = 96..127)
        run_to(100);
        load_valid = 1'b1;
        load_data  = 32'h00000F00;
        load_blank = 8'h01;
        tick();
        check("ldA.ready_after", 32'(load_ready), 32'd0);
        load_data  = 32'h00000005;
        load_blank = 8'h00;
        run_to(110);
        check("ldB.blocked", 32'(load_ready), 32'd0);
        disp_check("ldA.still_old", 4, 10, 0);
        run_to(127);
        check("ldA.frame_done", 32'(frame_done), 32'd1);
        check("ldB.blocked_fd", 32'(load_ready), 32'd0);
        tick();
        check("ldA.ready_commit", 32'(load_ready), 32'd1);
        tick();
        load_valid = 1'b0;
        check("ldB.transferred", 32'(load_ready), 32'd0);
        exp_nib = '{4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        exp_blk = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int p = 0; p < 8; p++) begin
            run_to(130 + 4 * p);
            disp_check("ldA.frame", 7 - p, 32'(exp_nib[p]), 32'(exp_blk[p]));
        end
        run_to(160);
        check("ldB.ready_commit", 32'(load_ready), 32'd1);
        run_to(162);
        disp_check("ldB.p0", 7, 5, 0);
        run_to(166);
        disp_check("ldB.p1", 6, 0, 1);

        // Load exactly in the frame_done cycle with pending empty
        run_to(191);
        check("ldC.frame_done", 32'(frame_done), 32'd1);
        check("ldC.ready_at_fd", 32'(load_ready), 32'd1);
        load_valid = 1'b1;
        load_data  = 32'h00C0FFEE;
        load_blank = 8'h00;
        tick();
        load_valid = 1'b0;
        check("ldC.ready_next", 32'(load_ready), 32'd1);
        tick();
        check("ldC.ready_next2", 32'(load_ready), 32'd1);
        exp_nib = '{4'hE, 4'hE, 4'hF, 4'hF, 4'h0, 4'hC, 4'h0, 4'h0};
        exp_blk = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int p = 0; p < 8; p++) begin
            run_to(194 + 4 * p);
            disp_check("ldC.frame", 7 - p, 32'(exp_nib[p]), 32'(exp_blk[p]));
        end

        // Reset mid-frame with pending full
        run_to(226);
        load_valid = 1'b1;
        load_data  = 32'h87654321;
        load_blank = 8'h00;
        tick();
        load_valid = 1'b0;
        check("ldD.ready_after", 32'(load_ready), 32'd0);
        run_to(230);
        disp_check("ldD.pre_rst", 6, 14, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        cyc   = 0;
        check("rst2.load_ready", 32'(load_ready), 32'd1);
        check("rst2.frame_done", 32'(frame_done), 32'd0);
        disp_check("rst2", 7, 0, 0);
        run_to(31);
        check("rst2.frame_done31", 32'(frame_done), 32'd1);
        run_to(34);
        disp_check("rst2.p0", 7, 0, 0);
        run_to(38);
        disp_check("rst2.p1", 6, 0, 1);
        check("rst2.ready_later", 32'(load_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
